// File: rtl/raifes_pc_redirect_ctrl_if.sv
// raifes_pc_redirect_ctrl_if: redirect requests in, PC mux select, kills and status out
interface raifes_pc_redirect_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 stall_IF;
  logic                 branch_taken_DX;
  logic                 jal_DX;
  logic                 jalr_DX;
  logic                 exception_WB;
  logic                 eret_WB;
  logic                 debug_halt_req;
  logic                 debug_resume;
  logic [2:0]           PC_src_sel;
  logic                 kill_IF;
  logic                 kill_DX;
  logic                 redirect_pending;
  logic                 halted;
  logic [CNT_WIDTH-1:0] redirect_count;
  modport master (
    output stall_IF, branch_taken_DX, jal_DX, jalr_DX, exception_WB, eret_WB,
           debug_halt_req, debug_resume,
    input  PC_src_sel, kill_IF, kill_DX, redirect_pending, halted, redirect_count
  );
  modport slave (
    input  stall_IF, branch_taken_DX, jal_DX, jalr_DX, exception_WB, eret_WB,
           debug_halt_req, debug_resume,
    output PC_src_sel, kill_IF, kill_DX, redirect_pending, halted, redirect_count
  );
endinterface

// File: rtl/raifes_pc_redirect_ctrl.sv
// raifes_pc_redirect_ctrl: next-PC source arbitration with stall hold, debug halt/resume and saturating redirect count
module raifes_pc_redirect_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  raifes_pc_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, PENDING, HALTED, RESUME} state_t;
  state_t state_q, state_d;
  logic [2:0] pend_q, pend_d, ev, code;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic win, inc, redir, halt, stall;
  function automatic logic [2:0] rank(input logic [2:0] c);
    return c == 3'd5 ? 3'd5 : c == 3'd6 ? 3'd4 : c;
  endfunction
  assign halt  = bus.debug_halt_req;
  assign stall = bus.stall_IF;
  assign redir = state_q == RUN || state_q == PENDING;
  always_comb begin
    ev = bus.exception_WB ? 3'd5 : bus.eret_WB ? 3'd6 : bus.jalr_DX ? 3'd3 :
         bus.jal_DX ? 3'd2 : bus.branch_taken_DX ? 3'd1 : 3'd0;
    win = rank(ev) > rank(pend_q);
    code = win ? ev : pend_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pend_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= inc && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  always_comb begin
    state_d = state_q == RUN     ? (halt ? HALTED : code != 3'd0 && stall ? PENDING : RUN) :
              state_q == PENDING ? (halt ? HALTED : stall ? PENDING : RUN) :
              state_q == HALTED  ? (bus.debug_resume ? RESUME : HALTED) :
                                   (stall ? RESUME : RUN);
    pend_d = redir && !halt && stall ? code : 3'd0;
    inc = !stall && (state_q == RESUME || (redir && !halt && code != 3'd0));
  end
  always_comb begin
    bus.PC_src_sel = state_q == HALTED ? 3'd4 : state_q == RESUME ? 3'd7 :
                     halt ? 3'd4 : code != 3'd0 ? code : stall ? 3'd4 : 3'd0;
    bus.kill_IF = !redir || halt || code != 3'd0;
    bus.kill_DX = redir && (halt || (win && (ev == 3'd5 || ev == 3'd6)));
    bus.redirect_pending = state_q == PENDING;
    bus.halted = state_q == HALTED || state_q == RESUME;
    bus.redirect_count = cnt_q;
  end
endmodule

// File: tb/tb_raifes_pc_redirect_ctrl.sv
// tb_raifes_pc_redirect_ctrl: directed and random checks against a behavioural next-PC model
module tb_raifes_pc_redirect_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  raifes_pc_redirect_ctrl_if #(.CNT_WIDTH(16)) bus ();
  raifes_pc_redirect_ctrl_if #(.CNT_WIDTH(2)) bus2 ();
  raifes_pc_redirect_ctrl #(.CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  raifes_pc_redirect_ctrl #(.CNT_WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  assign bus2.stall_IF        = bus.stall_IF;
  assign bus2.branch_taken_DX = bus.branch_taken_DX;
  assign bus2.jal_DX          = bus.jal_DX;
  assign bus2.jalr_DX         = bus.jalr_DX;
  assign bus2.exception_WB    = bus.exception_WB;
  assign bus2.eret_WB         = bus.eret_WB;
  assign bus2.debug_halt_req  = bus.debug_halt_req;
  assign bus2.debug_resume    = bus.debug_resume;
  // model: pending target code (0 = none), halt / resume flags, two counters
  int m_pend, m_cnt, m_cnt2;
  bit m_halt, m_resume;
  int e_sel;
  bit e_kif, e_kdx, e_rp, e_h;
  int pri_code [5] = '{5, 6, 3, 2, 1};
  function automatic int rk(input int c);
    for (int i = 0; i < 5; i++) if (pri_code[i] == c) return i;
    return 5;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_clear();
    m_pend = 0; m_cnt = 0; m_cnt2 = 0; m_halt = 0; m_resume = 0;
  endtask
  task automatic consume();
    m_cnt  = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
    m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : m_cnt2;
  endtask
  task automatic model_step(input bit st, br, jl, jr, ex, er, hq, rs);
    bit req [5];
    int ei, tgt;
    req = '{ex, er, jr, jl, br};
    ei = 5;
    for (int i = 4; i >= 0; i--) if (req[i]) ei = i;
    e_kdx = 0; e_rp = 0; e_h = 0;
    if (m_resume) begin
      e_sel = 7; e_kif = 1; e_h = 1;
      if (!st) begin consume(); m_resume = 0; end
    end else if (m_halt) begin
      e_sel = 4; e_kif = 1; e_h = 1;
      if (rs) begin m_halt = 0; m_resume = 1; end
    end else if (hq) begin
      e_sel = 4; e_kif = 1; e_kdx = 1; e_rp = m_pend != 0;
      m_pend = 0; m_halt = 1;
    end else begin
      e_rp = m_pend != 0;
      tgt = m_pend;
      if (ei < rk(m_pend)) begin
        tgt = pri_code[ei];
        e_kdx = tgt >= 5;
      end
      if (tgt == 0) begin
        e_sel = st ? 4 : 0; e_kif = 0;
      end else begin
        e_sel = tgt; e_kif = 1;
        if (!st) begin consume(); m_pend = 0; end else m_pend = tgt;
      end
    end
  endtask
  task automatic cmp_all(input int cnt_exp, input int cnt2_exp);
    chk("sel", 32'(bus.PC_src_sel), 32'(e_sel));
    chk("kill_IF", 32'(bus.kill_IF), 32'(e_kif));
    chk("kill_DX", 32'(bus.kill_DX), 32'(e_kdx));
    chk("redirect_pending", 32'(bus.redirect_pending), 32'(e_rp));
    chk("halted", 32'(bus.halted), 32'(e_h));
    chk("redirect_count", 32'(bus.redirect_count), 32'(cnt_exp));
    chk("sel_w2", 32'(bus2.PC_src_sel), 32'(e_sel));
    chk("redirect_count_w2", 32'(bus2.redirect_count), 32'(cnt2_exp));
  endtask
  task automatic cyc(input bit st, br, jl, jr, ex, er, hq, rs);
    int c, c2;
    @(negedge clk);
    reset = 0;
    bus.stall_IF = st; bus.branch_taken_DX = br; bus.jal_DX = jl; bus.jalr_DX = jr;
    bus.exception_WB = ex; bus.eret_WB = er; bus.debug_halt_req = hq; bus.debug_resume = rs;
    #1;
    c = m_cnt; c2 = m_cnt2;
    model_step(st, br, jl, jr, ex, er, hq, rs);
    cmp_all(c, c2);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    bus.stall_IF = 0; bus.branch_taken_DX = 0; bus.jal_DX = 0; bus.jalr_DX = 0;
    bus.exception_WB = 0; bus.eret_WB = 0; bus.debug_halt_req = 0; bus.debug_resume = 0;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_sel", 32'(bus.PC_src_sel), 0);
    chk("rst_kill_IF", 32'(bus.kill_IF), 0);
    chk("rst_kill_DX", 32'(bus.kill_DX), 0);
    chk("rst_pending", 32'(bus.redirect_pending), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_count", 32'(bus.redirect_count), 0);
  endtask
  initial begin
    model_clear();
    do_reset();
    cyc(0,0,0,0,0,0,0,0); chk("lit_idle_sel", 32'(bus.PC_src_sel), 0);
    cyc(1,0,0,0,0,0,0,0); chk("lit_stall_sel", 32'(bus.PC_src_sel), 4);
    chk("lit_stall_kif", 32'(bus.kill_IF), 0);
    cyc(0,0,0,0,0,0,0,0); chk("lit_unstall_sel", 32'(bus.PC_src_sel), 0);
    cyc(0,1,1,0,0,0,0,0); chk("lit_jal_sel", 32'(bus.PC_src_sel), 2);
    chk("lit_jal_kif", 32'(bus.kill_IF), 1); chk("lit_jal_kdx", 32'(bus.kill_DX), 0);
    cyc(0,0,0,0,0,0,0,0); chk("lit_jal_cnt", 32'(bus.redirect_count), 1);
    cyc(1,0,0,1,0,0,0,0); chk("lit_jalr_c1", 32'(bus.PC_src_sel), 3);
    chk("lit_jalr_c1_rp", 32'(bus.redirect_pending), 0);
    cyc(1,1,0,0,0,0,0,0); chk("lit_jalr_c2", 32'(bus.PC_src_sel), 3);
    chk("lit_jalr_c2_rp", 32'(bus.redirect_pending), 1);
    cyc(1,0,0,0,0,0,0,0); chk("lit_jalr_c3_cnt", 32'(bus.redirect_count), 1);
    cyc(0,0,0,0,0,0,0,0); chk("lit_jalr_c4", 32'(bus.PC_src_sel), 3);
    cyc(0,0,0,0,0,0,0,0); chk("lit_jalr_cnt", 32'(bus.redirect_count), 2);
    chk("lit_jalr_rp_clear", 32'(bus.redirect_pending), 0);
    cyc(1,0,1,0,0,0,0,0); chk("lit_pjal_sel", 32'(bus.PC_src_sel), 2);
    cyc(1,0,0,0,1,0,0,0); chk("lit_pexc_sel", 32'(bus.PC_src_sel), 5);
    chk("lit_pexc_kdx", 32'(bus.kill_DX), 1);
    cyc(0,0,0,0,0,0,0,0); chk("lit_pexc_hold", 32'(bus.PC_src_sel), 5);
    cyc(0,0,0,0,0,0,0,0); chk("lit_pexc_cnt", 32'(bus.redirect_count), 3);
    cyc(0,0,0,0,0,0,1,0); chk("lit_halt_sel", 32'(bus.PC_src_sel), 4);
    chk("lit_halt_kdx", 32'(bus.kill_DX), 1);
    cyc(0,0,0,0,1,0,1,0); chk("lit_halted", 32'(bus.halted), 1);
    chk("lit_halted_sel", 32'(bus.PC_src_sel), 4);
    cyc(0,0,0,0,0,0,0,1);
    cyc(1,0,0,0,0,0,0,0); chk("lit_resume_sel", 32'(bus.PC_src_sel), 7);
    cyc(0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0); chk("lit_resume_run", 32'(bus.halted), 0);
    chk("lit_resume_cnt", 32'(bus.redirect_count), 4);
    cyc(1,0,1,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0); chk("lit_mid_pending", 32'(bus.redirect_pending), 1);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0,0,1,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    chk("lit_sat_w2", 32'(bus2.redirect_count), 3);
    chk("lit_nosat_w16", 32'(bus.redirect_count), 5);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
